// File: rtl/port_d_nibble_tx.sv
// Result-return transmitter: buffers 32-bit result words and serves them to the MCU
// one nibble per request toggle on port_d_out, preceded by a status nibble.
module port_d_nibble_tx #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] word_data,
   input  logic        word_valid,
   output logic        word_ready,
   input  logic        mcu_req,
   input  logic        mcu_abort,
   output logic [3:0]  port_d_out
);

   localparam int             PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [2:0]     DEPTH_CNT = 3'(FIFO_DEPTH);
   localparam logic [1:0]     PRIME_CYCLES = 2'd3;

   typedef enum logic {
      ST_STATUS,
      ST_DATA
   } state_t;

   // ------------------------------------------------------------------
   // MCU input synchronizers and advance detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] req_sync;
   logic                   req_ref;
   logic [SYNC_STAGES-1:0] abort_sync;
   logic [1:0]             prime_cnt;
   logic                   priming;
   logic                   abort_s;
   logic                   advance;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours; blocking here would collapse the chain.
   always_ff @(posedge clock) begin
      if (reset) begin
         req_sync   <= '0;
         req_ref    <= 1'b0;
         abort_sync <= '0;
         prime_cnt  <= PRIME_CYCLES;
      end else begin
         req_sync[0]   <= mcu_req;
         abort_sync[0] <= mcu_abort;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            req_sync[i]   <= req_sync[i-1];
            abort_sync[i] <= abort_sync[i-1];
         end
         req_ref <= req_sync[SYNC_STAGES-1];
         if (prime_cnt != 2'd0)
            prime_cnt <= prime_cnt - 2'd1;
      end
   end

   assign priming = (prime_cnt != 2'd0);
   assign abort_s = abort_sync[SYNC_STAGES-1];
   // The edge reference tracks unconditionally, so masked toggles are consumed silently.
   assign advance = (req_sync[SYNC_STAGES-1] ^ req_ref) && !priming && !abort_s;

   // ------------------------------------------------------------------
   // Result word FIFO
   // ------------------------------------------------------------------
   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [2:0]       count;
   logic             push;
   logic             pop;
   logic [31:0]      head_word;

   // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot.
   assign word_ready = !priming && (count < DEPTH_CNT);
   assign push       = word_valid && word_ready;
   assign head_word  = fifo_mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and count define validity,
   // and leaving the data unreset lets it map onto plain registers or RAM.
   always_ff @(posedge clock) begin
      if (push)
         fifo_mem[wr_ptr] <= word_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 3'd0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   state_t      state, state_n;
   logic [31:0] shift_reg, shift_n;
   logic [2:0]  nib_cnt, nib_n;
   logic [3:0]  out_n;
   logic [3:0]  status_nib;

   assign status_nib = {count != 3'd0, count};

   // NOTE: every output of this block gets a default first; a path that skipped
   // an assignment would otherwise infer a latch.
   always_comb begin
      state_n = state;
      shift_n = shift_reg;
      nib_n   = nib_cnt;
      out_n   = port_d_out;
      pop     = 1'b0;

      if (abort_s) begin
         state_n = ST_STATUS;
         out_n   = status_nib;
      end else if (advance) begin
         case (state)
            ST_STATUS: begin
               // Only the displayed nonempty bit decides; the MCU acts on what it read.
               if (port_d_out[3]) begin
                  pop     = 1'b1;
                  shift_n = head_word;
                  out_n   = head_word[31:28];
                  nib_n   = 3'd0;
                  state_n = ST_DATA;
               end else begin
                  out_n = status_nib;
               end
            end
            ST_DATA: begin
               if (nib_cnt != 3'd7) begin
                  shift_n = shift_reg << 4;
                  out_n   = shift_reg[27:24];
                  nib_n   = nib_cnt + 3'd1;
               end else begin
                  state_n = ST_STATUS;
                  out_n   = status_nib;
               end
            end
            default: begin
               state_n = ST_STATUS;
               out_n   = status_nib;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_STATUS;
         shift_reg  <= 32'h0;
         nib_cnt    <= 3'd0;
         port_d_out <= 4'h0;
      end else begin
         state      <= state_n;
         shift_reg  <= shift_n;
         nib_cnt    <= nib_n;
         port_d_out <= out_n;
      end
   end

endmodule

// File: tb/tb_port_d_nibble_tx.sv
// Directed bench for port_d_nibble_tx: a queue-based model of the MCU-visible
// protocol is compared every cycle, plus literal nibble expectations per scenario.
module tb_port_d_nibble_tx;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready;
   logic        mcu_req;
   logic        mcu_abort;
   logic [3:0]  port_d_out;

   int checks = 0;
   int errors = 0;

   port_d_nibble_tx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .mcu_req    (mcu_req),
      .mcu_abort  (mcu_abort),
      .port_d_out (port_d_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Protocol model: words in a queue, what the MCU sees, and the input
   // history (an input toggle becomes an advance three edges later).
   // ------------------------------------------------------------------
   logic [31:0] mq[$];
   logic [3:0]  m_disp;
   bit          m_in_data;
   int          m_idx;
   logic [31:0] m_word;
   int          m_since;
   logic [2:0]  m_req_h;
   logic [2:0]  m_ab_h;
   bit          m_live = 1'b0;
   bit          m_ok, m_push, m_adv;
   logic [3:0]  m_status;

   always @(posedge clock) begin
      if (reset) begin
         mq.delete();
         m_disp    = 4'h0;
         m_in_data = 1'b0;
         m_idx     = 0;
         m_since   = 0;
         m_req_h   = 3'b000;
         m_ab_h    = 3'b000;
         m_live    = 1'b1;
      end else if (m_live) begin
         m_ok     = (m_since >= 3);
         m_push   = word_valid && m_ok && (mq.size() < DEPTH);
         m_status = {mq.size() != 0, 3'(mq.size())};
         m_adv    = m_ok && (m_req_h[1] != m_req_h[2]) && !m_ab_h[1];
         if (m_ab_h[1]) begin
            m_in_data = 1'b0;
            m_disp    = m_status;
         end else if (m_adv) begin
            if (!m_in_data) begin
               if (m_disp[3]) begin
                  m_word    = mq.pop_front();
                  m_idx     = 0;
                  m_in_data = 1'b1;
                  m_disp    = m_word[31:28];
               end else begin
                  m_disp = m_status;
               end
            end else if (m_idx < 7) begin
               m_idx++;
               m_disp = m_word[31-4*m_idx -: 4];
            end else begin
               m_in_data = 1'b0;
               m_disp    = m_status;
            end
         end
         if (m_push)
            mq.push_back(word_data);
         if (m_since < 1000)
            m_since++;
         m_req_h = {m_req_h[1:0], mcu_req};
         m_ab_h  = {m_ab_h[1:0], mcu_abort};
      end
   end

   always @(negedge clock) begin
      if (m_live) begin
         check("model_port_d_out", {28'h0, port_d_out}, {28'h0, m_disp});
         check("model_word_ready", {31'h0, word_ready},
               {31'h0, (m_since >= 3) && (mq.size() < DEPTH)});
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change on the falling edge)
   // ------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic toggle_expect(input string name, input logic [3:0] exp);
      mcu_req = ~mcu_req;
      tick(8);
      check(name, {28'h0, port_d_out}, {28'h0, exp});
   endtask

   task automatic push_one(input logic [31:0] d);
      word_valid = 1'b1;
      word_data  = d;
      tick(1);
      word_valid = 1'b0;
   endtask

   task automatic send_word(input string name, input logic [31:0] w, input int first,
                            input logic [3:0] status_after);
      for (int i = first; i < 8; i++)
         toggle_expect(name, w[31-4*i -: 4]);
      toggle_expect({name, "_status"}, status_after);
   endtask

   logic [31:0] words [6];

   initial begin
      words[0] = 32'hA1B2_C3D4;
      words[1] = 32'h5566_7788;
      words[2] = 32'h99AA_BBCC;
      words[3] = 32'h0F1E_2D3C;
      words[4] = 32'h4B5A_6978;
      words[5] = 32'hC0FF_EE42;

      reset      = 1'b1;
      mcu_req    = 1'b1;
      mcu_abort  = 1'b0;
      word_valid = 1'b0;
      word_data  = 32'h0;
      tick(3);

      // Reset and prime with mcu_req held high
      check("reset_out", {28'h0, port_d_out}, 32'h0);
      check("reset_ready", {31'h0, word_ready}, 32'h0);
      reset = 1'b0;
      tick(1);
      check("prime_ready_1", {31'h0, word_ready}, 32'h0);
      tick(1);
      check("prime_ready_2", {31'h0, word_ready}, 32'h0);
      tick(1);
      check("prime_ready_3", {31'h0, word_ready}, 32'h1);
      tick(6);
      check("prime_no_advance", {28'h0, port_d_out}, 32'h0);

      // Empty polling, then one word
      for (int i = 0; i < 5; i++)
         toggle_expect("empty_poll", 4'h0);
      push_one(32'h1234_5678);
      toggle_expect("poll_status", 4'h9);
      send_word("word_12345678", 32'h1234_5678, 0, 4'h0);

      // Single word with latency check on the status toggle
      push_one(32'hDEAD_BEEF);
      mcu_req = ~mcu_req;
      tick(2);
      check("latency_before", {28'h0, port_d_out}, 32'h0);
      tick(1);
      check("latency_after", {28'h0, port_d_out}, 32'h9);
      tick(5);
      send_word("word_deadbeef", 32'hDEAD_BEEF, 0, 4'h0);

      // Full FIFO: fifth word held until a pop frees a slot
      word_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         word_data = words[i];
         tick(1);
      end
      check("full_ready_low", {31'h0, word_ready}, 32'h0);
      word_data = words[4];
      tick(2);
      check("full_ready_held", {31'h0, word_ready}, 32'h0);
      toggle_expect("full_status", 4'hC);
      send_word("word_a", words[0], 0, 4'hC);
      word_valid = 1'b0;
      send_word("word_b", words[1], 0, 4'hB);
      send_word("word_c", words[2], 0, 4'hA);

      // Push in the same cycle as the pop from STATUS
      mcu_req = ~mcu_req;
      tick(2);
      word_valid = 1'b1;
      word_data  = words[5];
      tick(1);
      word_valid = 1'b0;
      check("simul_first_nibble", {28'h0, port_d_out}, {28'h0, words[3][31:28]});
      tick(5);
      send_word("word_d", words[3], 1, 4'hA);

      // Abort after three data nibbles, with a toggle during the abort window
      toggle_expect("abort_pre_n0", 4'h4);
      toggle_expect("abort_pre_n1", 4'hB);
      toggle_expect("abort_pre_n2", 4'h5);
      mcu_abort = 1'b1;
      tick(3);
      check("abort_in_effect", {28'h0, port_d_out}, 32'h9);
      mcu_req = ~mcu_req;
      tick(7);
      mcu_abort = 1'b0;
      tick(8);
      check("abort_status", {28'h0, port_d_out}, 32'h9);
      toggle_expect("after_abort_n0", 4'hC);
      send_word("word_f", words[5], 1, 4'h0);

      // Reset in the middle of a word
      push_one(32'h8765_4321);
      toggle_expect("midreset_status", 4'h9);
      toggle_expect("midreset_n0", 4'h8);
      toggle_expect("midreset_n1", 4'h7);
      reset = 1'b1;
      tick(1);
      check("midreset_out", {28'h0, port_d_out}, 32'h0);
      check("midreset_ready", {31'h0, word_ready}, 32'h0);
      reset = 1'b0;
      tick(4);
      check("postreset_ready", {31'h0, word_ready}, 32'h1);
      toggle_expect("postreset_empty", 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
